// File: rtl/aer_transmitter.sv
// Sending end of an inter-chip AER link: pops spike events from the on-chip FIFO
// and transmits each one over a 4-phase req/ack handshake with setup time and timeout.
module aer_transmitter #(
  parameter int VECTOR_WIDTH   = 5,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic [VECTOR_WIDTH-1:0] fifo_data,
  output logic                    fifo_read_en,
  output logic [VECTOR_WIDTH-1:0] aer_addr,
  output logic                    aer_req,
  input  logic                    aer_ack,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [COUNT_WIDTH-1:0]  event_count
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    SETUP   = 3'd2,
    REQ     = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic            ack_s1, ack_s;
  logic [7:0]      setup_cnt;
  logic [TO_W-1:0] to_cnt;

  logic load_addr, setup_inc, req_set, req_clr, to_clr, to_inc, to_fire, count_inc;

  assign fifo_read_en = (state == FETCH);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ack_s1      <= 1'b0;
      ack_s       <= 1'b0;
      aer_addr    <= '0;
      aer_req     <= 1'b0;
      setup_cnt   <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
      event_count <= '0;
    end else begin
      state  <= state_nxt;
      ack_s1 <= aer_ack;
      ack_s  <= ack_s1;

      // Address is captured only on FETCH, so it holds through the whole handshake
      if (load_addr) begin
        aer_addr  <= fifo_data;
        setup_cnt <= '0;
      end else if (setup_inc) begin
        setup_cnt <= setup_cnt + 8'd1;
      end

      if (req_set) aer_req <= 1'b1;
      else if (req_clr) aer_req <= 1'b0;

      if (to_clr) to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + TO_W'(1);

      if (to_fire) timeout_err <= 1'b1;
      if (count_inc) event_count <= event_count + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    load_addr = 1'b0;
    setup_inc = 1'b0;
    req_set   = 1'b0;
    req_clr   = 1'b0;
    to_clr    = 1'b0;
    to_inc    = 1'b0;
    to_fire   = 1'b0;
    count_inc = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = FETCH;
      end
      FETCH: begin
        load_addr = 1'b1;
        state_nxt = SETUP;
      end
      SETUP: begin
        if (setup_cnt == SETUP_LAST) begin
          req_set   = 1'b1;
          to_clr    = 1'b1;
          state_nxt = REQ;
        end else begin
          setup_inc = 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_clr   = 1'b1;
          to_clr    = 1'b1;
          state_nxt = RELEASE;
        end else if (TO_EN && (to_cnt == TO_LAST)) begin
          req_clr   = 1'b1;
          to_fire   = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_inc = 1'b1;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          count_inc = 1'b1;
          state_nxt = IDLE;
        end else if (TO_EN && (to_cnt == TO_LAST)) begin
          to_fire   = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aer_transmitter.sv
// Bench for aer_transmitter: queue-based FIFO and receiver models, scoreboard of
// transmitted addresses, and protocol monitors for setup latency and address stability.
module tb_aer_transmitter;
  localparam int VW    = 5;
  localparam int SETUP = 2;
  localparam int TMO   = 8;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [VW-1:0] fifo_data = '0;
  logic          fifo_read_en;
  logic [VW-1:0] aer_addr;
  logic          aer_req;
  logic          aer_ack = 1'b0;
  logic          busy;
  logic          timeout_err;
  logic [CW-1:0] event_count;

  int checks = 0;
  int failures = 0;
  int cnt_model = 0;
  bit mute = 1'b0;
  int fix_dly = -1;

  logic [VW-1:0] fifo_q[$];
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] rx_q[$];

  int            rx_st = 0;
  int            rx_cnt = 0;
  logic [VW-1:0] rx_addr = '0;

  int            fetch_age = -1;
  logic          req_prev = 1'b0;
  logic          rd_prev = 1'b0;
  logic [VW-1:0] addr_prev = '0;

  always #5 clk = ~clk;

  aer_transmitter #(
    .VECTOR_WIDTH(VW), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read_en(fifo_read_en), .aer_addr(aer_addr), .aer_req(aer_req),
    .aer_ack(aer_ack), .busy(busy), .timeout_err(timeout_err), .event_count(event_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Upstream FIFO: pops on the negedge of the read cycle, word valid before the next posedge.
  always @(negedge clk) begin
    if (fifo_read_en && !reset) begin
      chk("read_nonempty", int'(fifo_q.size() > 0), 1);
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Remote receiver: ack after a delay, release after req drops, log address on completion.
  always @(negedge clk) begin
    if (reset) begin
      rx_st   = 0;
      aer_ack = 1'b0;
    end else begin
      case (rx_st)
        0: if (aer_req && !mute) begin
          rx_addr = aer_addr;
          rx_cnt  = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
          rx_st   = 1;
        end
        1: if (rx_cnt == 0) begin aer_ack = 1'b1; rx_st = 2; end else rx_cnt--;
        2: if (!aer_req) begin
          rx_cnt = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
          rx_st  = 3;
        end
        default: if (rx_cnt == 0) begin
          aer_ack = 1'b0;
          rx_q.push_back(rx_addr);
          rx_st = 0;
        end else rx_cnt--;
      endcase
    end
  end

  // Protocol monitor: req rises SETUP+1 samples after the fetch, address steady while req high.
  always @(negedge clk) begin
    if (reset) begin
      fetch_age = -1;
      req_prev  = 1'b0;
      rd_prev   = 1'b0;
    end else begin
      if (fifo_read_en) chk("read_pulse_width", int'(rd_prev), 0);
      if (fifo_read_en) fetch_age = 0;
      else if (fetch_age >= 0) fetch_age++;
      if (aer_req && !req_prev) begin
        chk("req_latency", fetch_age, SETUP + 1);
        chk("addr_setup", int'(aer_addr), int'(addr_prev));
        fetch_age = -1;
      end else if (aer_req && req_prev) begin
        chk("addr_stable", int'(aer_addr), int'(addr_prev));
      end
      req_prev  = aer_req;
      rd_prev   = fifo_read_en;
      addr_prev = aer_addr;
    end
  end

  task automatic push(input logic [VW-1:0] v);
    @(posedge clk);
    #2;
    fifo_q.push_back(v);
    exp_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic lvl);
    int n = 0;
    while (aer_req !== lvl && n < 100) begin @(negedge clk); n++; end
    chk(tag, int'(aer_req), int'(lvl));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    int got = 0;
    int e;
    logic [VW-1:0] a;
    while (!(fifo_q.size() == 0 && fifo_empty && !busy && rx_st == 0 && !aer_ack) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, int'(n < 2000), 1);
    while (rx_q.size() > 0) begin
      a = rx_q.pop_front();
      e = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
      chk({tag, "_order"}, int'(a), e);
      got++;
    end
    chk({tag, "_pending"}, exp_q.size(), 0);
    cnt_model = (cnt_model + got) % (1 << CW);
    chk({tag, "_count"}, int'(event_count), cnt_model);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    logic [VW-1:0] v;

    // Reset values are visible with no clock edge.
    #1;
    chk("rst_req", int'(aer_req), 0);
    chk("rst_addr", int'(aer_addr), 0);
    chk("rst_read", int'(fifo_read_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(timeout_err), 0);
    chk("rst_count", int'(event_count), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_read", int'(fifo_read_en), 0);
      chk("idle_req", int'(aer_req), 0);
      chk("idle_busy", int'(busy), 0);
    end
    chk("idle_count", int'(event_count), 0);

    fix_dly = 3;
    push(5'b00011);
    drain("single");
    fix_dly = -1;
    chk("single_busy", int'(busy), 0);
    chk("single_count", int'(event_count), 1);

    for (int i = 1; i <= 6; i++) push(5'(i));
    drain("burst");
    chk("burst_fifo_empty", int'(fifo_empty), 1);
    chk("burst_count", int'(event_count), 7);

    // Receiver silent: request must be abandoned after TMO cycles and the event dropped.
    mute = 1'b1;
    push(5'b10101);
    wait_req("tmo_req_rise", 1'b1);
    hi = 0;
    while (aer_req && hi < 50) begin hi++; @(negedge clk); end
    chk("tmo_req_width", hi, TMO);
    chk("tmo_err", int'(timeout_err), 1);
    chk("tmo_count", int'(event_count), cnt_model);
    chk("tmo_busy", int'(busy), 0);
    void'(exp_q.pop_front());
    mute = 1'b0;
    push(5'b01110);
    drain("after_tmo");
    chk("tmo_err_sticky", int'(timeout_err), 1);
    chk("count_wrap8", int'(event_count), 0);

    // Reset during an open request.
    mute = 1'b1;
    push(5'b11001);
    wait_req("rstmid_req_rise", 1'b1);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_req", int'(aer_req), 0);
    chk("rstmid_addr", int'(aer_addr), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_err", int'(timeout_err), 0);
    chk("rstmid_count", int'(event_count), 0);
    void'(exp_q.pop_front());
    cnt_model = 0;
    @(negedge clk);
    reset = 1'b0;
    mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_idle", int'(busy), 0);

    for (int i = 0; i < 9; i++) begin
      v = 5'($urandom_range(0, 31));
      push(v);
    end
    drain("wrap");
    chk("wrap_count", int'(event_count), 1);

    for (int r = 0; r < 4; r++) begin
      int n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        v = 5'($urandom_range(0, 31));
        push(v);
        repeat ($urandom_range(0, 12)) @(posedge clk);
      end
      drain("rand");
    end
    chk("final_err_clear", int'(timeout_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
